// File: rtl/dcache_sa_store.sv
// Set-associative D-cache storage: tag/data arrays, valid/dirty/replacement state and flush walker.
// Build option DCACHE_PLRU_EN: per-set tree pseudo-LRU; otherwise a global round-robin pointer.
module dcache_sa_store #(
  parameter int INDEX_SIZE    = 6,
  parameter int WORD_OFF_SIZE = 4,
  parameter int TAG_SIZE      = 20,
  parameter int WAYS          = 2,
  localparam int LINE_W = 32 * (2 ** WORD_OFF_SIZE),
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [INDEX_SIZE-1:0]    req_index,
  input  logic [TAG_SIZE-1:0]      req_tag,
  input  logic [WORD_OFF_SIZE-1:0] req_off,
  output logic                     rsp_valid,
  output logic                     rsp_hit,
  output logic [WAY_W-1:0]         rsp_way,
  output logic [31:0]              rsp_word,
  output logic                     vic_valid,
  output logic                     vic_dirty,
  output logic [TAG_SIZE-1:0]      vic_tag,
  output logic [LINE_W-1:0]        vic_line,
  input  logic                     wr_en,
  input  logic [INDEX_SIZE-1:0]    wr_index,
  input  logic [WAY_W-1:0]         wr_way,
  input  logic [WORD_OFF_SIZE-1:0] wr_off,
  input  logic [3:0]               wr_strb,
  input  logic [31:0]              wr_data,
  input  logic                     fill_en,
  input  logic [INDEX_SIZE-1:0]    fill_index,
  input  logic [WAY_W-1:0]         fill_way,
  input  logic [TAG_SIZE-1:0]      fill_tag,
  input  logic [LINE_W-1:0]        fill_line,
  input  logic                     fill_dirty,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     flush_done,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [31:0]              wb_addr,
  output logic [LINE_W-1:0]        wb_line
);
  localparam int SETS = 2 ** INDEX_SIZE;
  localparam int LVL  = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} flush_state_t;

  logic [TAG_SIZE-1:0]   tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]     data_mem [WAYS][SETS];
  logic [WAYS-1:0]       valid_q  [SETS];
  logic [WAYS-1:0]       dirty_q  [SETS];
  flush_state_t          state;
  logic [INDEX_SIZE-1:0] fl_set;
  logic [WAY_W-1:0]      fl_way;
  logic                  req_fire, wr_do, fill_do, fl_last, fl_step, hit_c;
  logic [WAY_W-1:0]      hit_way_c, sel_way, repl_way;

`ifdef DCACHE_PLRU_EN
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
  logic [PLRU_W-1:0] plru_q [SETS];

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; each bit points toward the LRU half.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
    int unsigned node;
    logic [WAY_W-1:0] v;
    node = 0;
    v = '0;
    for (int unsigned l = 0; l < LVL; l++) begin
      v = (v << 1) | WAY_W'(t[node]);
      node = 2 * node + 1 + {31'b0, t[node]};
    end
    return v;
  endfunction

  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                   input logic [WAY_W-1:0] w);
    int unsigned node;
    logic dir;
    logic [PLRU_W-1:0] r;
    node = 0;
    r = t;
    for (int unsigned l = 0; l < LVL; l++) begin
      dir = w[WAY_W-1-l];
      r[node] = ~dir;
      node = 2 * node + 1 + {31'b0, dir};
    end
    return r;
  endfunction

  assign repl_way = plru_victim(plru_q[req_index]);
`else
  logic [WAY_W-1:0] rr_ptr;
  assign repl_way = rr_ptr;
`endif

  assign req_ready = ~flush_busy;
  assign req_fire  = req_valid & req_ready;
  assign fill_do   = fill_en & ~flush_busy;
  assign wr_do     = wr_en & ~flush_busy &
                     ~(fill_do && fill_index == wr_index && fill_way == wr_way);
  assign fl_last   = (fl_set == '1) && (fl_way == WAY_W'(WAYS - 1));
  assign fl_step   = ((state == SCAN) && !(valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way])) ||
                     ((state == WB) && wb_ready);

  // Scanning from the top way down leaves the lowest qualifying way selected.
  always_comb begin
    logic [WAY_W-1:0] w;
    w         = '0;
    hit_c     = 1'b0;
    hit_way_c = '0;
    sel_way   = repl_way;
    for (int unsigned i = 0; i < WAYS; i++) begin
      w = WAY_W'(WAYS - 1 - i);
      if (valid_q[req_index][w] && tag_mem[w][req_index] == req_tag) begin
        hit_c     = 1'b1;
        hit_way_c = w;
      end
    end
    if (hit_c) begin
      sel_way = hit_way_c;
    end else begin
      for (int unsigned i = 0; i < WAYS; i++) begin
        w = WAY_W'(WAYS - 1 - i);
        if (!valid_q[req_index][w]) sel_way = w;
      end
    end
  end

  // Fill is issued after the store so it overrides a store to the same set+way.
  always_ff @(posedge clk) begin
    if (wr_do) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_strb[b])
          data_mem[wr_way][wr_index][{wr_off, b[1:0], 3'b000} +: 8] <= wr_data[{b[1:0], 3'b000} +: 8];
      end
    end
    if (fill_do) begin
      tag_mem[fill_way][fill_index]  <= fill_tag;
      data_mem[fill_way][fill_index] <= fill_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      vic_valid <= 1'b0;
      vic_dirty <= 1'b0;
    end else begin
      rsp_valid <= req_fire;
      if (req_fire) begin
        rsp_hit   <= hit_c;
        rsp_way   <= sel_way;
        rsp_word  <= data_mem[sel_way][req_index][{req_off, 5'b00000} +: 32];
        vic_valid <= valid_q[req_index][sel_way];
        vic_dirty <= dirty_q[req_index][sel_way];
        vic_tag   <= tag_mem[sel_way][req_index];
        vic_line  <= data_mem[sel_way][req_index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
`ifdef DCACHE_PLRU_EN
        plru_q[s]  <= '0;
`endif
      end
`ifndef DCACHE_PLRU_EN
      rr_ptr     <= '0;
`endif
      state      <= IDLE;
      fl_set     <= '0;
      fl_way     <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      wb_valid   <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if (wr_do) dirty_q[wr_index][wr_way] <= 1'b1;
      if (fill_do) begin
        valid_q[fill_index][fill_way] <= 1'b1;
        dirty_q[fill_index][fill_way] <= fill_dirty;
      end
`ifdef DCACHE_PLRU_EN
      // A hit and a fill in the same set both touch the tree, hit first.
      if (req_fire && hit_c) plru_q[req_index] <= plru_touch(plru_q[req_index], hit_way_c);
      if (fill_do)
        plru_q[fill_index] <= plru_touch((req_fire && hit_c && req_index == fill_index) ?
                                         plru_touch(plru_q[fill_index], hit_way_c) :
                                         plru_q[fill_index], fill_way);
`else
      if (fill_do) rr_ptr <= (rr_ptr == WAY_W'(WAYS - 1)) ? '0 : rr_ptr + 1'b1;
`endif
      case (state)
        IDLE: if (flush_req) begin
          state      <= SCAN;
          flush_busy <= 1'b1;
          fl_set     <= '0;
          fl_way     <= '0;
        end
        SCAN: if (!fl_step) begin
          state    <= WB;
          wb_valid <= 1'b1;
          wb_addr  <= {tag_mem[fl_way][fl_set], fl_set, {(WORD_OFF_SIZE + 2){1'b0}}};
          wb_line  <= data_mem[fl_way][fl_set];
        end
        WB: if (wb_ready) wb_valid <= 1'b0;
        DONE: begin
          state      <= IDLE;
          flush_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (fl_step) begin
        valid_q[fl_set][fl_way] <= 1'b0;
        dirty_q[fl_set][fl_way] <= 1'b0;
        if (fl_way == WAY_W'(WAYS - 1)) begin
          fl_way <= '0;
          fl_set <= fl_set + 1'b1;
        end else begin
          fl_way <= fl_way + 1'b1;
        end
        if (fl_last) begin
          state      <= DONE;
          flush_done <= 1'b1;
        end else begin
          state <= SCAN;
        end
      end
    end
  end
endmodule

// File: tb/tb_dcache_sa_store.sv
// Scoreboarded random bench for dcache_sa_store against a behavioural cache model.
module tb_dcache_sa_store;
  localparam int IW = 6, OW = 4, TW = 20, WAYS = 2, SETS = 64, LW = 512, WW = 1;

  logic clk = 1'b0, resetn = 1'b0;
  logic req_valid, req_ready, rsp_valid, rsp_hit, vic_valid, vic_dirty;
  logic [IW-1:0] req_index, wr_index, fill_index;
  logic [TW-1:0] req_tag, vic_tag, fill_tag;
  logic [OW-1:0] req_off, wr_off;
  logic [WW-1:0] rsp_way, wr_way, fill_way;
  logic [31:0] rsp_word, wr_data, wb_addr;
  logic [LW-1:0] vic_line, fill_line, wb_line;
  logic wr_en, fill_en, fill_dirty, flush_req, flush_busy, flush_done, wb_valid, wb_ready;
  logic [3:0] wr_strb;

  dcache_sa_store #(.INDEX_SIZE(IW), .WORD_OFF_SIZE(OW), .TAG_SIZE(TW), .WAYS(WAYS)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_tag(req_tag), .req_off(req_off), .rsp_valid(rsp_valid),
    .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_word(rsp_word), .vic_valid(vic_valid),
    .vic_dirty(vic_dirty), .vic_tag(vic_tag), .vic_line(vic_line), .wr_en(wr_en),
    .wr_index(wr_index), .wr_way(wr_way), .wr_off(wr_off), .wr_strb(wr_strb),
    .wr_data(wr_data), .fill_en(fill_en), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_line(fill_line), .fill_dirty(fill_dirty),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_line(wb_line));

  always #5 clk = ~clk;

  typedef struct {
    logic hit; int way; logic [31:0] word;
    logic vv; logic vd; logic [TW-1:0] vt; logic [LW-1:0] vl;
  } rsp_t;
  typedef struct { logic [31:0] addr; logic [LW-1:0] line; } wb_t;
  rsp_t rq[$];
  wb_t  wq[$];
  int checks = 0, errors = 0, wb_beats = 0;

  // Reference cache state
  bit            m_v    [WAYS][SETS];
  bit            m_d    [WAYS][SETS];
  logic [TW-1:0] m_tag  [WAYS][SETS];
  logic [LW-1:0] m_line [WAYS][SETS];
  int            m_rr;
  int            m_lru  [SETS];
  logic [TW-1:0] tagpool [3] = '{20'h11111, 20'h22222, 20'h33333};

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin m_v[w][s] = 0; m_d[w][s] = 0; end
  endtask

  function automatic rsp_t model_lookup(int s, logic [TW-1:0] t, int off);
    rsp_t r;
    int w = -1;
    for (int i = WAYS - 1; i >= 0; i--) if (m_v[i][s] && m_tag[i][s] == t) w = i;
    r.hit = (w >= 0);
    if (w < 0) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!m_v[i][s]) w = i;
`ifdef DCACHE_PLRU_EN
      if (w < 0) w = m_lru[s];
`else
      if (w < 0) w = m_rr;
`endif
    end
    r.way  = w;
    r.word = m_line[w][s][off*32 +: 32];
    r.vv   = m_v[w][s];
    r.vd   = m_d[w][s];
    r.vt   = m_tag[w][s];
    r.vl   = m_line[w][s];
    return r;
  endfunction

  // One non-flush cycle: predict the response from pre-write state, then apply writes.
  task automatic step();
    rsp_t e;
    if (req_valid) begin
      e = model_lookup(int'(req_index), req_tag, int'(req_off));
      rq.push_back(e);
`ifdef DCACHE_PLRU_EN
      if (e.hit) m_lru[req_index] = 1 - e.way;
`endif
    end
    if (wr_en && !(fill_en && fill_index == wr_index && fill_way == wr_way)) begin
      for (int b = 0; b < 4; b++)
        if (wr_strb[b]) m_line[wr_way][wr_index][int'(wr_off)*32 + b*8 +: 8] = wr_data[b*8 +: 8];
      m_d[wr_way][wr_index] = 1;
    end
    if (fill_en) begin
      m_v[fill_way][fill_index]    = 1;
      m_d[fill_way][fill_index]    = fill_dirty;
      m_tag[fill_way][fill_index]  = fill_tag;
      m_line[fill_way][fill_index] = fill_line;
      m_rr = (m_rr + 1) % WAYS;
`ifdef DCACHE_PLRU_EN
      m_lru[fill_index] = 1 - int'(fill_way);
`endif
    end
    @(posedge clk); #2;
  endtask

  task automatic set_idle();
    req_valid = 0; wr_en = 0; fill_en = 0; flush_req = 0; fill_dirty = 0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic lookup(input int s, input logic [TW-1:0] t, input int off);
    req_valid = 1; req_index = IW'(s); req_tag = t; req_off = OW'(off);
    step(); set_idle();
  endtask

  task automatic fill(input int s, input int w, input logic [TW-1:0] t, input logic [LW-1:0] l,
                      input logic d);
    fill_en = 1; fill_index = IW'(s); fill_way = WW'(w); fill_tag = t; fill_line = l; fill_dirty = d;
    step(); set_idle();
  endtask

  task automatic store(input int s, input int w, input int off, input logic [3:0] st,
                       input logic [31:0] d);
    wr_en = 1; wr_index = IW'(s); wr_way = WW'(w); wr_off = OW'(off); wr_strb = st; wr_data = d;
    step(); set_idle();
  endtask

  task automatic rand_cycle(input bit wide);
    req_valid  = 1'($urandom_range(0, 1));
    req_index  = wide ? IW'($urandom) : IW'($urandom_range(0, 3));
    req_tag    = tagpool[$urandom_range(0, 2)];
    req_off    = OW'($urandom);
    wr_en      = ($urandom_range(0, 3) == 0);
    wr_index   = IW'($urandom_range(0, 3));
    wr_way     = WW'($urandom);
    wr_off     = OW'($urandom);
    wr_strb    = 4'($urandom);
    wr_data    = $urandom;
    fill_en    = ($urandom_range(0, 4) == 0);
    fill_index = wide ? IW'($urandom) : IW'($urandom_range(0, 3));
    fill_way   = WW'($urandom);
    fill_tag   = tagpool[$urandom_range(0, 2)];
    fill_line  = rand_line();
    fill_dirty = 1'($urandom_range(0, 1));
    step();
    set_idle();
  endtask

  // Full flush; expected writebacks are the dirty valid lines in set-major, way-minor order.
  task automatic do_flush(input bit stall3, input int budget);
    int n = 0, stall = 0, beats0, exp_beats;
    bit seen = 0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_v[w][s] && m_d[w][s]) wq.push_back('{addr: {m_tag[w][s], IW'(s), 6'b0}, line: m_line[w][s]});
    exp_beats = wq.size();
    beats0 = wb_beats;
    flush_req = 1;
    @(posedge clk); #2;
    flush_req = 0;
    chk("flush_busy_start", LW'(flush_busy), LW'(1));
    chk("req_ready_busy", LW'(req_ready), LW'(0));
    while (!seen && n < budget) begin
      if (flush_done) seen = 1;
      else begin
        if (wb_valid) begin
          if (stall3) begin
            if (stall < 3) begin wb_ready = 0; stall++; end
            else begin wb_ready = 1; stall = 0; end
          end else wb_ready = 1'($urandom_range(0, 1));
        end else wb_ready = 0;
        if (!stall3) begin
          // Traffic that must be ignored while the walker runs.
          fill_en = 1'($urandom_range(0, 1)); fill_index = IW'($urandom); fill_way = WW'($urandom);
          fill_tag = tagpool[0]; fill_line = rand_line(); fill_dirty = 1;
          wr_en = 1'($urandom_range(0, 1)); wr_index = IW'($urandom); wr_way = WW'($urandom);
          wr_strb = 4'hf; wr_data = $urandom; flush_req = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #2;
        n++;
      end
    end
    set_idle();
    wb_ready = 0;
    chk("flush_done_seen", LW'(seen), LW'(1));
    @(posedge clk); #2;
    chk("flush_done_pulse", LW'(flush_done), LW'(0));
    chk("flush_busy_end", LW'(flush_busy), LW'(0));
    chk("wb_beats", LW'(wb_beats - beats0), LW'(exp_beats));
    chk("wb_queue_empty", LW'(wq.size()), LW'(0));
    wq.delete();
    model_clear();
  endtask

  always @(negedge clk) begin
    rsp_t e;
    wb_t b;
    if (resetn) begin
      if (rsp_valid) begin
        if (rq.size() == 0) chk("rsp_unexpected", LW'(1), LW'(0));
        else begin
          e = rq.pop_front();
          chk("rsp_hit", LW'(rsp_hit), LW'(e.hit));
          chk("rsp_way", LW'(rsp_way), LW'(e.way));
          if (e.hit) chk("rsp_word", LW'(rsp_word), LW'(e.word));
          chk("vic_valid", LW'(vic_valid), LW'(e.vv));
          chk("vic_dirty", LW'(vic_dirty), LW'(e.vd));
          if (e.vv) begin
            chk("vic_tag", LW'(vic_tag), LW'(e.vt));
            chk("vic_line", vic_line, e.vl);
          end
        end
      end
      if (wb_valid && wb_ready) begin
        wb_beats++;
        if (wq.size() == 0) chk("wb_unexpected", LW'(1), LW'(0));
        else begin
          b = wq.pop_front();
          chk("wb_addr", LW'(wb_addr), LW'(b.addr));
          chk("wb_line", wb_line, b.line);
        end
      end
    end
  end

  initial begin
    logic [LW-1:0] l;
    int n;
    set_idle(); wb_ready = 0;
    req_index = '0; req_tag = '0; req_off = '0; wr_index = '0; wr_way = '0; wr_off = '0;
    wr_strb = '0; wr_data = '0; fill_index = '0; fill_way = '0; fill_tag = '0; fill_line = '0;
    m_rr = 0;
    for (int s = 0; s < SETS; s++) m_lru[s] = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rsp_valid", LW'(rsp_valid), LW'(0));
    chk("reset_wb_valid", LW'(wb_valid), LW'(0));
    chk("reset_flush_busy", LW'(flush_busy), LW'(0));
    chk("reset_flush_done", LW'(flush_done), LW'(0));
    chk("reset_req_ready", LW'(req_ready), LW'(1));
    resetn = 1;
    @(posedge clk); #2;

    lookup(5, 20'h12345, 0);
    l = rand_line(); l[3*32 +: 32] = 32'hDEADBEEF;
    fill(5, 1, 20'hABCDE, l, 0);
    lookup(5, 20'hABCDE, 3);
    store(5, 1, 3, 4'b0011, 32'h00001234);
    lookup(5, 20'hABCDE, 3);
    fill(7, 0, 20'h00070, rand_line(), 0);
    fill(7, 1, 20'h00071, rand_line(), 0);
    lookup(7, 20'h00070, 1);
    lookup(7, 20'h00999, 0);
    store(7, 0, 9, 4'b1111, 32'hCAFEF00D);
    lookup(7, 20'h00070, 9);
    // Same-target fill and store: the fill content and dirty flag must survive.
    fill_en = 1; fill_index = 9; fill_way = 0; fill_tag = 20'h00009; fill_line = rand_line(); fill_dirty = 0;
    wr_en = 1; wr_index = 9; wr_way = 0; wr_off = 0; wr_strb = 4'hf; wr_data = 32'h5A5A5A5A;
    step(); set_idle();
    // Different targets in one cycle: both land.
    fill_en = 1; fill_index = 10; fill_way = 1; fill_tag = 20'h0000A; fill_line = rand_line(); fill_dirty = 0;
    wr_en = 1; wr_index = 9; wr_way = 0; wr_off = 2; wr_strb = 4'b0100; wr_data = 32'h00770000;
    step(); set_idle();
    lookup(9, 20'h00009, 0);
    lookup(9, 20'h00009, 2);
    lookup(10, 20'h0000A, 15);
    // Leave exactly two dirty lines (5/1 and 7/0) for the stalled writeback flush.
    fill(9, 0, 20'h00009, rand_line(), 0);
    step();
    do_flush(1'b1, 3000);
    for (int s = 0; s < SETS; s++) lookup(s, (s == 7) ? 20'h00070 : 20'hABCDE, 0);
    step();

    for (int i = 0; i < 400; i++) rand_cycle(i >= 300);
    step();
    do_flush(1'b0, 3000);
    for (int i = 0; i < 150; i++) rand_cycle(1'b0);
    step();

    // Reset while the walker is parked on a writeback.
    fill(2, 0, 20'h22222, rand_line(), 1);
    fill(3, 1, 20'h33333, rand_line(), 1);
    step();
    flush_req = 1;
    @(posedge clk); #2;
    flush_req = 0;
    n = 0;
    while (!wb_valid && n < 500) begin @(posedge clk); #2; n++; end
    chk("wb_valid_reached", LW'(wb_valid), LW'(1));
    repeat (2) @(posedge clk);
    #2;
    resetn = 0;
    @(posedge clk); #2;
    chk("abort_wb_valid", LW'(wb_valid), LW'(0));
    chk("abort_flush_busy", LW'(flush_busy), LW'(0));
    chk("abort_req_ready", LW'(req_ready), LW'(1));
    resetn = 1;
    model_clear();
    m_rr = 0;
    for (int s = 0; s < SETS; s++) m_lru[s] = 0;
    for (int s = 0; s < SETS; s++) lookup(s, tagpool[s % 3], 0);
    lookup(2, 20'h22222, 0);
    lookup(3, 20'h33333, 0);
    step();
    step();
    chk("rsp_queue_drained", LW'(rq.size()), LW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
